// File: rtl/zap_register_file_ctx.sv
// ZAP core register file: 2 write ports, RD_PORTS combinational read ports and a
// context engine that streams a register range out (SAVE) or in (RESTORE).
module zap_register_file_ctx #(
  parameter int DW       = 32,
  parameter int DEPTH    = 40,
  parameter int AW       = $clog2(DEPTH),
  parameter int CW       = $clog2(DEPTH + 1),
  parameter int RD_PORTS = 4,
  parameter int BYPASS   = 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_wen,
  input  logic [AW-1:0]          i_wr_addr_a,
  input  logic [DW-1:0]          i_wr_data_a,
  input  logic [AW-1:0]          i_wr_addr_b,
  input  logic [DW-1:0]          i_wr_data_b,
  input  logic [RD_PORTS*AW-1:0] i_rd_addr,
  output logic [RD_PORTS*DW-1:0] o_rd_data,
  input  logic                   i_ctx_start,
  input  logic                   i_ctx_mode,
  input  logic [AW-1:0]          i_ctx_base,
  input  logic [CW-1:0]          i_ctx_count,
  output logic                   o_ctx_busy,
  output logic                   o_ctx_done,
  output logic                   o_sv_valid,
  output logic [AW-1:0]          o_sv_addr,
  output logic [DW-1:0]          o_sv_data,
  input  logic                   i_sv_ready,
  input  logic                   i_rs_valid,
  input  logic [DW-1:0]          i_rs_data,
  output logic                   o_rs_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2,
    DONE    = 2'd3
  } state_t;

  logic [DW-1:0]          mem_q [DEPTH];
  logic [DW-1:0]          mem_d [DEPTH];
  state_t                 state_q;
  logic [AW-1:0]          ptr_q;
  logic [CW-1:0]          rem_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   sv_valid_q;
  logic [AW-1:0]          sv_addr_q;
  logic [DW-1:0]          sv_data_q;
  logic                   rs_ready_q;
  logic                   sv_beat_s;
  logic                   rs_beat_s;
  logic [AW-1:0]          ptr_next_s;
  logic [CW-1:0]          cnt_clamp_s;
  logic [RD_PORTS*DW-1:0] rd_data_s;

  // An out-of-range pointer also folds back to 0 so a bad base cannot run away.
  function automatic logic [AW-1:0] ptr_wrap(input logic [AW-1:0] p);
    logic [AW-1:0] n;
    if (int'(p) >= DEPTH - 1) begin
      n = '0;
    end else begin
      n = p + AW'(1);
    end
    return n;
  endfunction

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    if (int'(a) < DEPTH) begin
      w = mem_q[a];
    end else begin
      w = '0;
    end
    return w;
  endfunction

  assign sv_beat_s   = sv_valid_q & i_sv_ready;
  assign rs_beat_s   = rs_ready_q & i_rs_valid;
  assign ptr_next_s  = ptr_wrap(ptr_q);
  assign cnt_clamp_s = (int'(i_ctx_count) > DEPTH) ? CW'(DEPTH) : i_ctx_count;

  // Next register contents: port B beats port A beats a restore beat.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (i_wen && (i_wr_addr_b == AW'(i))) begin
        mem_d[i] = i_wr_data_b;
      end else if (i_wen && (i_wr_addr_a == AW'(i))) begin
        mem_d[i] = i_wr_data_a;
      end else if (rs_beat_s && (ptr_q == AW'(i))) begin
        mem_d[i] = i_rs_data;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (i_reset) begin
        mem_q[i] <= '0;
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Read ports; restore beats are deliberately not forwarded.
  always_comb begin
    rd_data_s = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      if (int'(i_rd_addr[k*AW +: AW]) >= DEPTH) begin
        rd_data_s[k*DW +: DW] = '0;
      end else if ((BYPASS != 0) && i_wen && (i_wr_addr_b == i_rd_addr[k*AW +: AW])) begin
        rd_data_s[k*DW +: DW] = i_wr_data_b;
      end else if ((BYPASS != 0) && i_wen && (i_wr_addr_a == i_rd_addr[k*AW +: AW])) begin
        rd_data_s[k*DW +: DW] = i_wr_data_a;
      end else begin
        rd_data_s[k*DW +: DW] = mem_word(i_rd_addr[k*AW +: AW]);
      end
    end
  end

  assign o_rd_data = i_reset ? '0 : rd_data_s;

  // Context engine. Save beats sample mem_q, i.e. the value before this edge's writes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sv_valid_q <= 1'b0;
      sv_addr_q  <= '0;
      sv_data_q  <= '0;
      rs_ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_ctx_start) begin
            ptr_q <= i_ctx_base;
            rem_q <= cnt_clamp_s;
            if (cnt_clamp_s == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (!i_ctx_mode) begin
              state_q    <= SAVE;
              busy_q     <= 1'b1;
              sv_valid_q <= 1'b1;
              sv_addr_q  <= i_ctx_base;
              sv_data_q  <= mem_word(i_ctx_base);
            end else begin
              state_q    <= RESTORE;
              busy_q     <= 1'b1;
              rs_ready_q <= 1'b1;
            end
          end
        end
        SAVE: begin
          if (sv_beat_s) begin
            ptr_q <= ptr_next_s;
            rem_q <= rem_q - CW'(1);
            if (rem_q == CW'(1)) begin
              state_q    <= DONE;
              busy_q     <= 1'b0;
              sv_valid_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              sv_addr_q <= ptr_next_s;
              sv_data_q <= mem_word(ptr_next_s);
            end
          end
        end
        RESTORE: begin
          if (rs_beat_s) begin
            ptr_q <= ptr_next_s;
            rem_q <= rem_q - CW'(1);
            if (rem_q == CW'(1)) begin
              state_q    <= DONE;
              busy_q     <= 1'b0;
              rs_ready_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          sv_valid_q <= 1'b0;
          rs_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_ctx_busy = busy_q;
  assign o_ctx_done = done_q;
  assign o_sv_valid = sv_valid_q;
  assign o_sv_addr  = sv_addr_q;
  assign o_sv_data  = sv_data_q;
  assign o_rs_ready = rs_ready_q;

endmodule

// File: tb/tb_zap_register_file_ctx.sv
// Directed bench for zap_register_file_ctx (DEPTH=40, DW=32, 4 read ports, bypass on).
module tb_zap_register_file_ctx;
  localparam int DW = 32;
  localparam int DEPTH = 40;
  localparam int AW = 6;
  localparam int CW = 6;
  localparam int RP = 4;

  logic            i_clk;
  logic            i_reset;
  logic            i_wen;
  logic [AW-1:0]   i_wr_addr_a;
  logic [DW-1:0]   i_wr_data_a;
  logic [AW-1:0]   i_wr_addr_b;
  logic [DW-1:0]   i_wr_data_b;
  logic [RP*AW-1:0] i_rd_addr;
  logic [RP*DW-1:0] o_rd_data;
  logic            i_ctx_start;
  logic            i_ctx_mode;
  logic [AW-1:0]   i_ctx_base;
  logic [CW-1:0]   i_ctx_count;
  logic            o_ctx_busy;
  logic            o_ctx_done;
  logic            o_sv_valid;
  logic [AW-1:0]   o_sv_addr;
  logic [DW-1:0]   o_sv_data;
  logic            i_sv_ready;
  logic            i_rs_valid;
  logic [DW-1:0]   i_rs_data;
  logic            o_rs_ready;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_mem [DEPTH];

  zap_register_file_ctx #(
    .DW(DW), .DEPTH(DEPTH), .AW(AW), .CW(CW), .RD_PORTS(RP), .BYPASS(1)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_wen(i_wen),
    .i_wr_addr_a(i_wr_addr_a), .i_wr_data_a(i_wr_data_a),
    .i_wr_addr_b(i_wr_addr_b), .i_wr_data_b(i_wr_data_b),
    .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
    .i_ctx_start(i_ctx_start), .i_ctx_mode(i_ctx_mode),
    .i_ctx_base(i_ctx_base), .i_ctx_count(i_ctx_count),
    .o_ctx_busy(o_ctx_busy), .o_ctx_done(o_ctx_done),
    .o_sv_valid(o_sv_valid), .o_sv_addr(o_sv_addr), .o_sv_data(o_sv_data),
    .i_sv_ready(i_sv_ready), .i_rs_valid(i_rs_valid), .i_rs_data(i_rs_data),
    .o_rs_ready(o_rs_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
    i_rd_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  function automatic logic [DW-1:0] rd(input int k);
    return o_rd_data[k*DW +: DW];
  endfunction

  task automatic test_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    checks++;
    if ({o_ctx_busy, o_ctx_done, o_sv_valid, o_rs_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b exp 0000", {o_ctx_busy, o_ctx_done, o_sv_valid, o_rs_ready});
    end
    checks++;
    if ({o_sv_addr, o_sv_data} !== {AW'(0), DW'(0)}) begin
      errors++;
      $display("FAIL reset_sv: got addr %0d data %h exp 0/0", o_sv_addr, o_sv_data);
    end
    for (int r = 0; r < DEPTH; r += 4) begin
      set_rd(r, r + 1, r + 2, r + 3);
      #1;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rd(k) !== exp_mem[r+k]) begin
          errors++;
          $display("FAIL reset_mem[%0d]: got %h exp %h", r + k, rd(k), exp_mem[r+k]);
        end
      end
    end
  endtask

  task automatic test_write_priority();
    tick();
    i_wen = 1'b1;
    i_wr_addr_a = 6'd3; i_wr_data_a = 32'h11;
    i_wr_addr_b = 6'd3; i_wr_data_b = 32'h22;
    set_rd(3, 0, 0, 0);
    #1;
    checks++;
    if (rd(0) !== 32'h22) begin
      errors++;
      $display("FAIL bypass_b_over_a: got %h exp %h", rd(0), 32'h22);
    end
    tick();
    exp_mem[3] = 32'h22;
    i_wr_addr_a = 6'd4; i_wr_data_a = 32'h44;
    i_wr_addr_b = 6'd5; i_wr_data_b = 32'h55;
    set_rd(4, 5, 3, 0);
    #1;
    checks++;
    if ({rd(0), rd(1), rd(2)} !== {32'h44, 32'h55, 32'h22}) begin
      errors++;
      $display("FAIL bypass_a_b: got %h %h %h exp 44 55 22", rd(0), rd(1), rd(2));
    end
    tick();
    i_wen = 1'b0;
    exp_mem[4] = 32'h44;
    exp_mem[5] = 32'h55;
    set_rd(3, 4, 5, 0);
    #1;
    checks++;
    if ({rd(0), rd(1), rd(2)} !== {32'h22, 32'h44, 32'h55}) begin
      errors++;
      $display("FAIL write_stored: got %h %h %h exp 22 44 55", rd(0), rd(1), rd(2));
    end
  endtask

  task automatic test_out_of_range();
    set_rd(45, 0, 0, 0);
    #1;
    checks++;
    if (rd(0) !== 32'h0) begin
      errors++;
      $display("FAIL oor_read: got %h exp 0", rd(0));
    end
    tick();
    i_wen = 1'b1;
    i_wr_addr_a = 6'd45; i_wr_data_a = 32'hDEAD;
    i_wr_addr_b = 6'd63; i_wr_data_b = 32'hBEEF;
    set_rd(45, 63, 0, 0);
    #1;
    checks++;
    if ({rd(0), rd(1)} !== {32'h0, 32'h0}) begin
      errors++;
      $display("FAIL oor_bypass: got %h %h exp 0 0", rd(0), rd(1));
    end
    tick();
    i_wen = 1'b0;
    for (int r = 0; r < DEPTH; r += 4) begin
      set_rd(r, r + 1, r + 2, r + 3);
      #1;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rd(k) !== exp_mem[r+k]) begin
          errors++;
          $display("FAIL oor_mem[%0d]: got %h exp %h", r + k, rd(k), exp_mem[r+k]);
        end
      end
    end
  endtask

  task automatic test_save();
    logic [AW-1:0] exp_a [4];
    logic [DW-1:0] exp_d [4];
    tick();
    i_wen = 1'b1;
    i_wr_addr_a = 6'd38; i_wr_data_a = 32'h3838;
    i_wr_addr_b = 6'd39; i_wr_data_b = 32'h3939;
    tick();
    i_wr_addr_a = 6'd0; i_wr_data_a = 32'h1000;
    i_wr_addr_b = 6'd1; i_wr_data_b = 32'h1001;
    tick();
    i_wen = 1'b0;
    exp_mem[38] = 32'h3838; exp_mem[39] = 32'h3939;
    exp_mem[0] = 32'h1000;  exp_mem[1] = 32'h1001;
    exp_a[0] = 6'd38; exp_a[1] = 6'd39; exp_a[2] = 6'd0; exp_a[3] = 6'd1;
    exp_d[0] = 32'h3838; exp_d[1] = 32'h3939; exp_d[2] = 32'h1000; exp_d[3] = 32'h1001;
    i_ctx_mode = 1'b0; i_ctx_base = 6'd38; i_ctx_count = 6'd4;
    i_sv_ready = 1'b0; i_ctx_start = 1'b1;
    tick();
    i_ctx_start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      i_sv_ready = 1'b0;
      checks++;
      if ({o_sv_valid, o_ctx_busy, o_ctx_done, o_sv_addr, o_sv_data} !== {3'b110, exp_a[j], exp_d[j]}) begin
        errors++;
        $display("FAIL save_beat%0d: got v%b b%b d%b addr %0d data %h exp v1 b1 d0 addr %0d data %h",
                 j, o_sv_valid, o_ctx_busy, o_ctx_done, o_sv_addr, o_sv_data, exp_a[j], exp_d[j]);
      end
      if (j == 1) begin
        i_ctx_start = 1'b1; i_ctx_mode = 1'b1; i_ctx_base = 6'd10; i_ctx_count = 6'd2;
      end
      tick();
      i_ctx_start = 1'b0; i_ctx_mode = 1'b0;
      checks++;
      if ({o_sv_valid, o_rs_ready, o_sv_addr, o_sv_data} !== {2'b10, exp_a[j], exp_d[j]}) begin
        errors++;
        $display("FAIL save_hold%0d: got v%b r%b addr %0d data %h exp v1 r0 addr %0d data %h",
                 j, o_sv_valid, o_rs_ready, o_sv_addr, o_sv_data, exp_a[j], exp_d[j]);
      end
      i_sv_ready = 1'b1;
      if (j == 0) begin
        i_wen = 1'b1; i_wr_addr_a = 6'd39; i_wr_data_a = 32'hBEEF;
        i_wr_addr_b = 6'd20; i_wr_data_b = 32'h2020;
      end
      tick();
      i_wen = 1'b0;
      i_sv_ready = 1'b0;
      if (j == 0) begin
        exp_mem[39] = 32'hBEEF;
        exp_mem[20] = 32'h2020;
      end
    end
    checks++;
    if ({o_ctx_done, o_ctx_busy, o_sv_valid} !== 3'b100) begin
      errors++;
      $display("FAIL save_done: got d%b b%b v%b exp d1 b0 v0", o_ctx_done, o_ctx_busy, o_sv_valid);
    end
    tick();
    set_rd(39, 20, 0, 0);
    #1;
    checks++;
    if ({o_ctx_done, o_ctx_busy, o_rs_ready} !== 3'b000) begin
      errors++;
      $display("FAIL save_idle: got d%b b%b r%b exp 000", o_ctx_done, o_ctx_busy, o_rs_ready);
    end
    checks++;
    if ({rd(0), rd(1)} !== {32'hBEEF, 32'h2020}) begin
      errors++;
      $display("FAIL save_core_write: got %h %h exp beef 2020", rd(0), rd(1));
    end
  endtask

  task automatic test_restore();
    i_ctx_mode = 1'b1; i_ctx_base = 6'd5; i_ctx_count = 6'd3; i_ctx_start = 1'b1;
    tick();
    i_ctx_start = 1'b0;
    checks++;
    if ({o_ctx_busy, o_rs_ready, o_sv_valid, o_ctx_done} !== 4'b1100) begin
      errors++;
      $display("FAIL restore_enter: got b%b r%b v%b d%b exp 1100", o_ctx_busy, o_rs_ready, o_sv_valid, o_ctx_done);
    end
    tick();
    i_rs_valid = 1'b1; i_rs_data = 32'hA;
    set_rd(5, 0, 0, 0);
    #1;
    checks++;
    if (rd(0) !== 32'h55) begin
      errors++;
      $display("FAIL restore_no_bypass: got %h exp %h", rd(0), 32'h55);
    end
    tick();
    i_rs_valid = 1'b0;
    tick();
    checks++;
    if ({o_rs_ready, o_ctx_done} !== 2'b10) begin
      errors++;
      $display("FAIL restore_gap: got r%b d%b exp r1 d0", o_rs_ready, o_ctx_done);
    end
    i_rs_valid = 1'b1; i_rs_data = 32'hB;
    i_wen = 1'b1; i_wr_addr_a = 6'd6; i_wr_data_a = 32'hFF;
    i_wr_addr_b = 6'd50; i_wr_data_b = 32'h0;
    tick();
    i_wen = 1'b0;
    i_rs_data = 32'hC;
    tick();
    i_rs_valid = 1'b0;
    exp_mem[5] = 32'hA; exp_mem[6] = 32'hFF; exp_mem[7] = 32'hC;
    checks++;
    if ({o_ctx_done, o_ctx_busy, o_rs_ready} !== 3'b100) begin
      errors++;
      $display("FAIL restore_done: got d%b b%b r%b exp 100", o_ctx_done, o_ctx_busy, o_rs_ready);
    end
    tick();
    checks++;
    if (o_ctx_done !== 1'b0) begin
      errors++;
      $display("FAIL restore_done_pulse: got %b exp 0", o_ctx_done);
    end
    for (int r = 0; r < DEPTH; r += 4) begin
      set_rd(r, r + 1, r + 2, r + 3);
      #1;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rd(k) !== exp_mem[r+k]) begin
          errors++;
          $display("FAIL restore_mem[%0d]: got %h exp %h", r + k, rd(k), exp_mem[r+k]);
        end
      end
    end
  endtask

  task automatic test_zero_count();
    tick();
    i_ctx_mode = 1'b0; i_ctx_base = 6'd7; i_ctx_count = 6'd0; i_ctx_start = 1'b1;
    #1;
    checks++;
    if (o_ctx_done !== 1'b0) begin
      errors++;
      $display("FAIL zero_pre: got done %b exp 0", o_ctx_done);
    end
    tick();
    i_ctx_start = 1'b0;
    checks++;
    if ({o_ctx_done, o_ctx_busy, o_sv_valid, o_rs_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL zero_done: got d%b b%b v%b r%b exp 1000", o_ctx_done, o_ctx_busy, o_sv_valid, o_rs_ready);
    end
    tick();
    checks++;
    if ({o_ctx_done, o_ctx_busy, o_sv_valid} !== 3'b000) begin
      errors++;
      $display("FAIL zero_after: got d%b b%b v%b exp 000", o_ctx_done, o_ctx_busy, o_sv_valid);
    end
  endtask

  task automatic test_reset_mid_save();
    i_ctx_mode = 1'b0; i_ctx_base = 6'd0; i_ctx_count = 6'd5; i_ctx_start = 1'b1;
    tick();
    i_ctx_start = 1'b0;
    i_sv_ready = 1'b1;
    tick();
    i_sv_ready = 1'b0;
    checks++;
    if ({o_sv_valid, o_sv_addr, o_sv_data} !== {1'b1, 6'd1, 32'h1001}) begin
      errors++;
      $display("FAIL midsave_beat: got v%b addr %0d data %h exp v1 addr 1 data 1001", o_sv_valid, o_sv_addr, o_sv_data);
    end
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    checks++;
    if ({o_ctx_busy, o_sv_valid, o_ctx_done, o_sv_addr, o_sv_data} !== {3'b000, AW'(0), DW'(0)}) begin
      errors++;
      $display("FAIL midsave_reset: got b%b v%b d%b addr %0d data %h exp all 0",
               o_ctx_busy, o_sv_valid, o_ctx_done, o_sv_addr, o_sv_data);
    end
    for (int r = 0; r < DEPTH; r += 4) begin
      set_rd(r, r + 1, r + 2, r + 3);
      #1;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rd(k) !== exp_mem[r+k]) begin
          errors++;
          $display("FAIL midsave_mem[%0d]: got %h exp %h", r + k, rd(k), exp_mem[r+k]);
        end
      end
    end
    tick();
    checks++;
    if ({o_ctx_done, o_ctx_busy} !== 2'b00) begin
      errors++;
      $display("FAIL midsave_no_done: got d%b b%b exp 00", o_ctx_done, o_ctx_busy);
    end
  endtask

  initial begin
    i_reset = 1'b1; i_wen = 1'b0;
    i_wr_addr_a = '0; i_wr_data_a = '0; i_wr_addr_b = '0; i_wr_data_b = '0;
    i_rd_addr = '0; i_ctx_start = 1'b0; i_ctx_mode = 1'b0; i_ctx_base = '0;
    i_ctx_count = '0; i_sv_ready = 1'b0; i_rs_valid = 1'b0; i_rs_data = '0;
    test_reset();
    test_write_priority();
    test_out_of_range();
    test_save();
    test_restore();
    test_zero_count();
    test_reset_mid_save();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
